kudu_bp_update_sched: RTL and testbench
=======================================

Name: kudu_bp_update_sched

Overview:
- Scheduler between the dual-issue issuer's branch-resolution outputs (lanes 0/1, lane 0 older) and the branch predictor's single-write-port update interface.
- Accepts up to two resolved branches per cycle and buffers them in age order in a small FIFO.
- Drains at most one update per cycle over a valid/ready handshake.
- When the FIFO lacks space, applies a fixed drop policy that preserves mispredict updates, and counts drops.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- AW, 32, PC/target width.
- CW, 16, drop-counter width.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- en_i  input  1  update enable; 0 ignores all lane inputs; FIFO still drains
- br_valid_i  input  2  per-lane resolved-branch strobe
- br_pc_i  input  2xAW  per-lane branch PC
- br_target_i  input  2xAW  per-lane branch target
- br_taken_i  input  2  per-lane actual direction
- br_miss_i  input  2  per-lane mispredict flag
- upd_valid_o  output  1  update entry available
- upd_ready_i  input  1  predictor accepts head entry
- upd_pc_o  output  AW  head PC
- upd_target_o  output  AW  head target
- upd_taken_o  output  1  head direction
- upd_miss_o  output  1  head mispredict flag
- occupancy_o  output  $clog2(DEPTH)+1  current entry count
- drop_cnt_o  output  CW  saturating count of dropped updates
- clr_drop_i  input  1  synchronous clear of drop_cnt_o

Behaviour:
- Reset: FIFO empty, rd/wr pointers 0, upd_valid_o=0, occupancy_o=0, drop_cnt_o=0. Data outputs are 0 while empty.
- Storage: circular buffer with pointers of $clog2(DEPTH)+1 bits; wrap-around at DEPTH, natural modulo.
- Pop: occurs when upd_valid_o && upd_ready_i. The head advances at the next edge. Outputs are driven from the head entry.
- Latency:
  - An entry enqueued at edge N is visible at the head from cycle N+1 if the FIFO was empty.
  - There is no same-cycle input-to-output bypass.
- Request vector: req[i] = en_i && br_valid_i[i].
- Space: space = DEPTH - occupancy + pop. Simultaneous push and pop in the same cycle is allowed when the FIFO is full.
- Acceptance:
  - space >= 2: all requests accepted; lane 0 written before lane 1.
  - space == 1 with both requesting: keep lane 1 only if br_miss_i = {1,0} (lane 1 mispredicted, lane 0 correct). Otherwise keep lane 0. The other request is dropped.
  - space == 1 with one requesting: accepted.
  - space == 0: all requests dropped.
- Ordering: accepted entries always retain lane order (lane 0 older).
- Drop counter:
  - Increments by the number of dropped requests (0/1/2) and saturates at all-ones.
  - clr_drop_i takes priority over a same-cycle increment; the result is 0.
- occupancy_o next = occupancy + accepted - pop. It never exceeds DEPTH and never underflows.
- Unguarded pop: upd_ready_i while empty has no effect.
- Reset mid-operation: all entries are discarded immediately (asynchronous), with no partial update presented.
- Assertions (sim only):
  - No push when occupancy == DEPTH without a pop.
  - Data stable while upd_valid_o && !upd_ready_i.

Decomposition:
- kudu_pkg gains typedef bp_update_t with fields pc, target, taken, miss. The FIFO stores bp_update_t.
- One natural sub-module, kudu_bp_upd_fifo: a dual-push/single-pop circular buffer with push count 0..2 and pop.
- The top level holds the request/space/drop arbitration and the drop counter.

Test Plan:
- Single branch: lane 0 pc=0x100, target=0x80, taken=1, miss=1, ready=1 -> upd_valid_o rises the next cycle with those values; pops one cycle later; occupancy_o 1 then 0.
- Dual issue, ready=0: lane 0 pc=0x200, lane 1 pc=0x204 -> occupancy_o=2; raising ready yields 0x200 then 0x204 on consecutive cycles.
- Fill with ready=0: three cycles of dual valid with DEPTH=4 -> occupancy_o=4, drop_cnt_o=2; head stays pc of the first entry.
- Space=1 policy: occupancy 3, ready=0, both valid, miss={1,0} -> lane 1 stored, drop_cnt_o +1. Repeat with miss={1,1} -> lane 0 stored.
- Full with simultaneous pop: occupancy 4, ready=1, lane 0 valid -> accepted, occupancy stays 4, no drop. en_i=0 with valid -> no enqueue.
- Counter: force drops to all-ones -> saturates. clr_drop_i together with a drop -> 0. Async reset mid-drain -> upd_valid_o=0 and occupancy_o=0 immediately.

Source files
------------

// File: rtl/kudu_pkg.sv
// Shared types for the kudu branch-predictor update path.
// bp_update_t is the record carried from branch resolution to the predictor write port.
package kudu_pkg;

  localparam int unsigned KUDU_AW = 32;

  typedef struct packed {
    logic [KUDU_AW-1:0] pc;
    logic [KUDU_AW-1:0] target;
    logic               taken;
    logic               miss;
  } bp_update_t;

  // Outcome of one cycle's lane arbitration.
  typedef enum logic [1:0] {
    PUSH_NONE = 2'd0,
    PUSH_ONE  = 2'd1,
    PUSH_TWO  = 2'd2
  } push_cnt_e;

endpackage

// File: rtl/kudu_bp_upd_fifo.sv
// Dual-push / single-pop circular buffer of bp_update_t.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module kudu_bp_upd_fifo
  import kudu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH) + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  push_cnt_e           push_cnt_i,
  input  bp_update_t [1:0]    push_data_i,
  input  logic                pop_i,
  output bp_update_t          head_o,
  output logic [PW-1:0]       count_o,
  output logic                empty_o
);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-2:0] wr_idx0;
  logic [PW-2:0] wr_idx1;
  logic          pop_eff;
  bp_update_t    mem [DEPTH];

  assign count_o = wr_ptr - rd_ptr;
  assign empty_o = (count_o == '0);
  assign pop_eff = pop_i && !empty_o;
  assign wr_idx0 = wr_ptr[PW-2:0];
  assign wr_idx1 = wr_ptr[PW-2:0] + (PW-1)'(1);
  assign head_o  = mem[rd_ptr[PW-2:0]];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_cnt_i);
      rd_ptr <= rd_ptr + PW'(pop_eff);
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are live, so resetting the data would only cost flops.
  always_ff @(posedge clk_i) begin
    if (push_cnt_i != PUSH_NONE) mem[wr_idx0] <= push_data_i[0];
    if (push_cnt_i == PUSH_TWO)  mem[wr_idx1] <= push_data_i[1];
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push_cnt_i != PUSH_NONE && count_o == PW'(DEPTH)) |-> pop_i);
`endif

endmodule

// File: rtl/kudu_bp_update_sched.sv
// Schedules up to two resolved branches per cycle into the predictor's single
// update port, buffering in age order and dropping (and counting) on overflow.
module kudu_bp_update_sched
  import kudu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned CW    = 16,
  localparam int unsigned PW   = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [1:0]           br_valid_i,
  input  logic [1:0][AW-1:0]   br_pc_i,
  input  logic [1:0][AW-1:0]   br_target_i,
  input  logic [1:0]           br_taken_i,
  input  logic [1:0]           br_miss_i,
  output logic                 upd_valid_o,
  input  logic                 upd_ready_i,
  output logic [AW-1:0]        upd_pc_o,
  output logic [AW-1:0]        upd_target_o,
  output logic                 upd_taken_o,
  output logic                 upd_miss_o,
  output logic [PW-1:0]        occupancy_o,
  output logic [CW-1:0]        drop_cnt_o,
  input  logic                 clr_drop_i
);

  logic [1:0]       req;
  logic             pop;
  logic             empty;
  logic [PW:0]      space;
  bp_update_t [1:0] lane_upd;
  bp_update_t [1:0] push_data;
  bp_update_t       head;
  push_cnt_e        push_cnt;
  logic [1:0]       drop;
  logic [CW:0]      drop_sum;

  assign req   = {2{en_i}} & br_valid_i;
  assign pop   = upd_valid_o && upd_ready_i;
  assign space = (PW+1)'(DEPTH) - {1'b0, occupancy_o} + (PW+1)'(pop);

  for (genvar i = 0; i < 2; i++) begin : g_lane
    assign lane_upd[i] = '{pc:     KUDU_AW'(br_pc_i[i]),
                           target: KUDU_AW'(br_target_i[i]),
                           taken:  br_taken_i[i],
                           miss:   br_miss_i[i]};
  end

  // Slot 0 is always the older accepted entry; a lone lane-1 request moves down.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    push_cnt  = PUSH_NONE;
    push_data = lane_upd;
    drop      = 2'd0;
    unique case (req)
      2'b01: begin
        if (space != '0) push_cnt = PUSH_ONE;
        else             drop     = 2'd1;
      end
      2'b10: begin
        push_data[0] = lane_upd[1];
        if (space != '0) push_cnt = PUSH_ONE;
        else             drop     = 2'd1;
      end
      2'b11: begin
        if (space >= (PW+1)'(2)) begin
          push_cnt = PUSH_TWO;
        end else if (space == (PW+1)'(1)) begin
          // Only a lane-1 mispredict behind a correct lane 0 wins the last slot.
          push_cnt = PUSH_ONE;
          drop     = 2'd1;
          if (br_miss_i == 2'b10) push_data[0] = lane_upd[1];
        end else begin
          drop = 2'd2;
        end
      end
      default: ;
    endcase
  end

  kudu_bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_cnt_i  (push_cnt),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (occupancy_o),
    .empty_o     (empty)
  );

  assign upd_valid_o  = !empty;
  assign upd_pc_o     = upd_valid_o ? AW'(head.pc)     : '0;
  assign upd_target_o = upd_valid_o ? AW'(head.target) : '0;
  assign upd_taken_o  = upd_valid_o && head.taken;
  assign upd_miss_o   = upd_valid_o && head.miss;

  assign drop_sum = {1'b0, drop_cnt_o} + (CW+1)'(drop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          drop_cnt_o <= '0;
    else if (clr_drop_i)  drop_cnt_o <= '0;
    else if (drop_sum[CW]) drop_cnt_o <= '1;
    else                  drop_cnt_o <= drop_sum[CW-1:0];
  end

`ifndef SYNTHESIS
  a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (upd_valid_o && !upd_ready_i) |=>
      $stable({upd_pc_o, upd_target_o, upd_taken_o, upd_miss_o}));
`endif

endmodule

// File: tb/tb_kudu_bp_update_sched.sv
// Scoreboard bench for kudu_bp_update_sched: the driver predicts accepted
// entries from a queue-level model, a separate monitor checks the update port.
module tb_kudu_bp_update_sched;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int CW    = 4;
  localparam int PW    = $clog2(DEPTH) + 1;
  localparam int DMAX  = (1 << CW) - 1;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                en_i;
  logic [1:0]          br_valid_i;
  logic [1:0][AW-1:0]  br_pc_i;
  logic [1:0][AW-1:0]  br_target_i;
  logic [1:0]          br_taken_i;
  logic [1:0]          br_miss_i;
  logic                upd_valid_o;
  logic                upd_ready_i;
  logic [AW-1:0]       upd_pc_o;
  logic [AW-1:0]       upd_target_o;
  logic                upd_taken_o;
  logic                upd_miss_o;
  logic [PW-1:0]       occupancy_o;
  logic [CW-1:0]       drop_cnt_o;
  logic                clr_drop_i;

  kudu_bp_update_sched #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .br_valid_i   (br_valid_i),
    .br_pc_i      (br_pc_i),
    .br_target_i  (br_target_i),
    .br_taken_i   (br_taken_i),
    .br_miss_i    (br_miss_i),
    .upd_valid_o  (upd_valid_o),
    .upd_ready_i  (upd_ready_i),
    .upd_pc_o     (upd_pc_o),
    .upd_target_o (upd_target_o),
    .upd_taken_o  (upd_taken_o),
    .upd_miss_o   (upd_miss_o),
    .occupancy_o  (occupancy_o),
    .drop_cnt_o   (drop_cnt_o),
    .clr_drop_i   (clr_drop_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] target;
    logic          taken;
    logic          miss;
  } exp_t;

  exp_t sb[$];
  int   m_occ  = 0;
  int   m_drop = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict its effect, commit after the edge.
  task automatic step(input bit en, input logic [1:0] v,
                      input logic [AW-1:0] p0, input logic [AW-1:0] t0,
                      input logic [AW-1:0] p1, input logic [AW-1:0] t1,
                      input logic [1:0] tk, input logic [1:0] ms,
                      input bit rdy, input bit clr);
    int   lanes[$];
    int   nreq;
    int   space;
    bit   pop;
    exp_t e;
    en_i = en; br_valid_i = v;
    br_pc_i[0] = p0; br_target_i[0] = t0;
    br_pc_i[1] = p1; br_target_i[1] = t1;
    br_taken_i = tk; br_miss_i = ms;
    upd_ready_i = rdy; clr_drop_i = clr;

    pop   = rdy && (m_occ > 0);
    space = DEPTH - m_occ + (pop ? 1 : 0);
    for (int i = 0; i < 2; i++) if (en && v[i]) lanes.push_back(i);
    nreq = lanes.size();
    if (nreq > space) begin
      if (space == 0) lanes.delete();
      else lanes = '{(ms == 2'b10) ? 1 : 0};
    end

    @(posedge clk_i);
    #1;
    if (pop) m_occ--;
    foreach (lanes[k]) begin
      e.pc     = (lanes[k] == 0) ? p0 : p1;
      e.target = (lanes[k] == 0) ? t0 : t1;
      e.taken  = tk[lanes[k]];
      e.miss   = ms[lanes[k]];
      sb.push_back(e);
    end
    m_occ += lanes.size();
    if (clr) m_drop = 0;
    else     m_drop = (m_drop + nreq - lanes.size() > DMAX) ? DMAX : m_drop + nreq - lanes.size();
  endtask

  task automatic idle(input bit rdy);
    step(1'b1, 2'b00, '0, '0, '0, '0, 2'b00, 2'b00, rdy, 1'b0);
  endtask

  task automatic dual(input logic [AW-1:0] p0, input logic [AW-1:0] p1,
                      input logic [1:0] ms, input bit rdy);
    step(1'b1, 2'b11, p0, p0 + 32'h40, p1, p1 + 32'h40, 2'b01, ms, rdy, 1'b0);
  endtask

  task automatic rand_step();
    step($urandom_range(0, 7) != 0, 2'($urandom), $urandom, $urandom, $urandom, $urandom,
         2'($urandom), 2'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
  endtask

  // Monitor: mid-cycle, inputs and outputs are settled.
  always @(negedge clk_i) begin
    if (mon_en && rst_ni) begin
      check("valid", 64'(upd_valid_o), 64'(m_occ > 0));
      check("occupancy", 64'(occupancy_o), 64'(m_occ));
      check("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
      if (upd_valid_o) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL head_unexpected actual=pc %0h expected=no entry at %0t", upd_pc_o, $time);
        end else begin
          check("head_pc", 64'(upd_pc_o), 64'(sb[0].pc));
          check("head_target", 64'(upd_target_o), 64'(sb[0].target));
          check("head_taken", 64'(upd_taken_o), 64'(sb[0].taken));
          check("head_miss", 64'(upd_miss_o), 64'(sb[0].miss));
          if (upd_ready_i) void'(sb.pop_front());
        end
      end else begin
        check("empty_pc_zero", 64'(upd_pc_o), 64'd0);
      end
    end
  end

  initial begin
    rst_ni = 1'b0; en_i = 1'b0; br_valid_i = '0; br_pc_i = '0; br_target_i = '0;
    br_taken_i = '0; br_miss_i = '0; upd_ready_i = 1'b0; clr_drop_i = 1'b0;
    #12;
    check("rst_valid", 64'(upd_valid_o), 64'd0);
    check("rst_occupancy", 64'(occupancy_o), 64'd0);
    check("rst_drop", 64'(drop_cnt_o), 64'd0);
    check("rst_pc", 64'(upd_pc_o), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    mon_en = 1'b1;

    // Single branch, then drain.
    step(1'b1, 2'b01, 32'h100, 32'h80, '0, '0, 2'b01, 2'b01, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Dual issue held, then released in order.
    dual(32'h200, 32'h204, 2'b00, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Fill past capacity: four stored, two dropped, then drain.
    dual(32'h300, 32'h304, 2'b00, 1'b0);
    dual(32'h308, 32'h30c, 2'b00, 1'b0);
    dual(32'h310, 32'h314, 2'b00, 1'b0);
    repeat (5) idle(1'b1);

    // One slot left: lane-1 mispredict wins, then both-miss keeps lane 0.
    dual(32'h400, 32'h404, 2'b00, 1'b0);
    step(1'b1, 2'b01, 32'h408, 32'h1, '0, '0, 2'b00, 2'b00, 1'b0, 1'b0);
    dual(32'h410, 32'h414, 2'b10, 1'b0);
    idle(1'b1);
    dual(32'h420, 32'h424, 2'b11, 1'b0);
    repeat (5) idle(1'b1);

    // Full with simultaneous pop; enable low ignores lanes.
    dual(32'h500, 32'h504, 2'b00, 1'b0);
    dual(32'h508, 32'h50c, 2'b00, 1'b0);
    step(1'b1, 2'b01, 32'h510, 32'h2, '0, '0, 2'b01, 2'b00, 1'b1, 1'b0);
    step(1'b0, 2'b11, 32'h520, 32'h3, 32'h524, 32'h4, 2'b11, 2'b11, 1'b0, 1'b0);

    // Saturate the drop counter, then clear alongside a drop.
    repeat (10) dual(32'h600, 32'h604, 2'b01, 1'b0);
    step(1'b1, 2'b11, 32'h610, 32'h5, 32'h614, 32'h6, 2'b00, 2'b00, 1'b0, 1'b1);
    dual(32'h620, 32'h624, 2'b00, 1'b0);

    // Asynchronous reset in the middle of a drain.
    idle(1'b1);
    en_i = 1'b0; br_valid_i = '0; clr_drop_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst_valid", 64'(upd_valid_o), 64'd0);
    check("midrst_occupancy", 64'(occupancy_o), 64'd0);
    check("midrst_drop", 64'(drop_cnt_o), 64'd0);
    sb.delete();
    m_occ = 0;
    m_drop = 0;
    @(negedge clk_i);
    #1;
    rst_ni = 1'b1;

    repeat (400) rand_step();
    repeat (DEPTH + 2) idle(1'b1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
